sc_gamestatus_tracker: RTL and testbench

- Responder end of the general game FSM's active-low command strobes: level increment and life decrement.
- Holds the lives and level counters and drives the status flags back to the FSM: lives comparator and levels comparator.
- Runs a small game-status FSM (PLAY/OVER/WIN) and emits a one-cycle level-load request to the lane/pattern loader.
- Sits between the general state machine, the start button and the 7-seg/matrix display.

---
 rtl/sc_gamestatus_tracker.sv | 142 ++++++++++++++
 tb/tb_sc_gamestatus_tracker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_gamestatus_tracker.sv
// Game-status tracker: lives/level counters, PLAY/OVER/WIN FSM and level-load pulse.
// Optional bonus-life logic is compiled only when SC_GAMESTATUS_BONUS_LIFE_EN is defined.
module sc_gamestatus_tracker #(
    parameter int MAX_LIVES   = 3,
    parameter int WIN_LEVEL   = 5,
    parameter int CNT_W       = 3,
    parameter int BONUS_EVERY = 2
) (
    input  logic             SC_GAMESTATUS_CLOCK_50,
    input  logic             SC_GAMESTATUS_RESET_InHigh,
    input  logic             SC_GAMESTATUS_contador_vidas_InLow,
    input  logic             SC_GAMESTATUS_contador_niveles_InLow,
    input  logic             SC_GAMESTATUS_startButton_InLow,
    output logic             SC_GAMESTATUS_COMPARATOR_LIVES,
    output logic             SC_GAMESTATUS_COMPARATOR_LEVELS,
    output logic [CNT_W-1:0] SC_GAMESTATUS_Lives_Out,
    output logic [CNT_W-1:0] SC_GAMESTATUS_Level_Out,
    output logic             SC_GAMESTATUS_LevelLoad_Out,
    output logic [1:0]       SC_GAMESTATUS_State_Out
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        OVER = 2'd1,
        WIN  = 2'd2
    } statusState_t;

    localparam logic [CNT_W-1:0] maxLives = CNT_W'(MAX_LIVES);
    localparam logic [CNT_W-1:0] winLevel = CNT_W'(WIN_LEVEL);
    localparam logic [CNT_W-1:0] cntOne   = CNT_W'(1);
`ifdef SC_GAMESTATUS_BONUS_LIFE_EN
    localparam logic [CNT_W-1:0] bonusEvery = CNT_W'(BONUS_EVERY);
`endif

    statusState_t     state;
    statusState_t     nextState;
    logic [CNT_W-1:0] lives;
    logic [CNT_W-1:0] nextLives;
    logic [CNT_W-1:0] level;
    logic [CNT_W-1:0] nextLevel;
    logic [CNT_W-1:0] levelPlusOne;
    logic             vidasPrev;
    logic             nivelesPrev;
    logic             startPrev;
    logic             decEvent;
    logic             incEvent;
    logic             startEvent;
    logic             decOk;
    logic             incOk;
    logic             goOver;
    logic             loadReq;
    logic             compLives;
    logic             compLevels;
    logic             levelLoad;

    // A falling edge on an active-low strobe is one event, however long it stays low.
    assign decEvent     = vidasPrev   & ~SC_GAMESTATUS_contador_vidas_InLow;
    assign incEvent     = nivelesPrev & ~SC_GAMESTATUS_contador_niveles_InLow;
    assign startEvent   = startPrev   & ~SC_GAMESTATUS_startButton_InLow;
    assign levelPlusOne = level + cntOne;

    always_ff @(posedge SC_GAMESTATUS_CLOCK_50) begin
        if (SC_GAMESTATUS_RESET_InHigh) begin
            state       <= PLAY;
            lives       <= maxLives;
            level       <= '0;
            vidasPrev   <= 1'b1;
            nivelesPrev <= 1'b1;
            startPrev   <= 1'b1;
            compLives   <= 1'b1;
            compLevels  <= 1'b0;
            levelLoad   <= 1'b0;
        end else begin
            state       <= nextState;
            lives       <= nextLives;
            level       <= nextLevel;
            vidasPrev   <= SC_GAMESTATUS_contador_vidas_InLow;
            nivelesPrev <= SC_GAMESTATUS_contador_niveles_InLow;
            startPrev   <= SC_GAMESTATUS_startButton_InLow;
            compLives   <= (lives != '0);
            compLevels  <= (level == winLevel);
            levelLoad   <= loadReq;
        end
    end

    // A decrement that empties lives wins over a same-cycle increment.
    always_comb begin
        nextState = state;
        nextLives = lives;
        nextLevel = level;
        loadReq   = 1'b0;
        decOk     = 1'b0;
        incOk     = 1'b0;
        goOver    = 1'b0;
        case (state)
            PLAY: begin
                decOk  = decEvent && (lives != '0);
                goOver = decOk && (lives == cntOne);
                incOk  = incEvent && (level < winLevel) && !goOver;
                if (decOk) begin
                    nextLives = lives - cntOne;
                end
                if (incOk) begin
                    nextLevel = levelPlusOne;
                    loadReq   = 1'b1;
`ifdef SC_GAMESTATUS_BONUS_LIFE_EN
                    if (((levelPlusOne % bonusEvery) == '0) && (levelPlusOne < winLevel)
                        && (nextLives < maxLives)) begin
                        nextLives = nextLives + cntOne;
                    end
`endif
                end
                if (goOver) begin
                    nextState = OVER;
                end else if (incOk && (levelPlusOne == winLevel)) begin
                    nextState = WIN;
                end
            end
            OVER, WIN: begin
                if (startEvent) begin
                    nextState = PLAY;
                    nextLives = maxLives;
                    nextLevel = '0;
                    loadReq   = 1'b1;
                end
            end
            default: begin
                nextState = PLAY;
            end
        endcase
    end

    always_comb begin
        SC_GAMESTATUS_COMPARATOR_LIVES  = compLives;
        SC_GAMESTATUS_COMPARATOR_LEVELS = compLevels;
        SC_GAMESTATUS_Lives_Out         = lives;
        SC_GAMESTATUS_Level_Out         = level;
        SC_GAMESTATUS_LevelLoad_Out     = levelLoad;
        SC_GAMESTATUS_State_Out         = state;
    end

endmodule

// File: tb/tb_sc_gamestatus_tracker.sv
// Directed self-checking bench for sc_gamestatus_tracker (default parameters).
module tb_sc_gamestatus_tracker;

    logic       clock50 = 1'b0;
    logic       resetInHigh;
    logic       vidasInLow;
    logic       nivelesInLow;
    logic       startInLow;
    logic       compLives;
    logic       compLevels;
    logic [2:0] livesOut;
    logic [2:0] levelOut;
    logic       levelLoad;
    logic [1:0] stateOut;

    int testCount = 0;
    int failCount = 0;

    sc_gamestatus_tracker dut (
        .SC_GAMESTATUS_CLOCK_50               (clock50),
        .SC_GAMESTATUS_RESET_InHigh           (resetInHigh),
        .SC_GAMESTATUS_contador_vidas_InLow   (vidasInLow),
        .SC_GAMESTATUS_contador_niveles_InLow (nivelesInLow),
        .SC_GAMESTATUS_startButton_InLow      (startInLow),
        .SC_GAMESTATUS_COMPARATOR_LIVES       (compLives),
        .SC_GAMESTATUS_COMPARATOR_LEVELS      (compLevels),
        .SC_GAMESTATUS_Lives_Out              (livesOut),
        .SC_GAMESTATUS_Level_Out              (levelOut),
        .SC_GAMESTATUS_LevelLoad_Out          (levelLoad),
        .SC_GAMESTATUS_State_Out              (stateOut)
    );

    always #5 clock50 = ~clock50;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock50);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic vidas, input logic niveles, input logic start);
        vidasInLow   = vidas;
        nivelesInLow = niveles;
        startInLow   = start;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle low pulse; outputs are sampled just after the edge that consumes it.
    task automatic pulse(input logic vidas, input logic niveles, input logic start);
        applyStimulus(vidas, niveles, start);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        resetInHigh = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(2);
        resetInHigh = 1'b0;
        checkOutput("rst_lives", 8'(livesOut), 8'd3);
        checkOutput("rst_level", 8'(levelOut), 8'd0);
        checkOutput("rst_state", 8'(stateOut), 8'd0);
        checkOutput("rst_cmpLives", 8'(compLives), 8'd1);
        checkOutput("rst_cmpLevels", 8'(compLevels), 8'd0);
        checkOutput("rst_load", 8'(levelLoad), 8'd0);

        pulse(1'b0, 1'b1, 1'b1);
        checkOutput("dec1_lives", 8'(livesOut), 8'd2);
        checkOutput("dec1_state", 8'(stateOut), 8'd0);
        tick(1);
        pulse(1'b0, 1'b1, 1'b1);
        checkOutput("dec2_lives", 8'(livesOut), 8'd1);
        tick(1);
        pulse(1'b0, 1'b1, 1'b1);
        checkOutput("dec3_lives", 8'(livesOut), 8'd0);
        checkOutput("dec3_state", 8'(stateOut), 8'd1);
        checkOutput("dec3_cmpLives_lag", 8'(compLives), 8'd1);
        tick(1);
        checkOutput("dec3_cmpLives", 8'(compLives), 8'd0);
        pulse(1'b0, 1'b1, 1'b1);
        checkOutput("dec4_lives", 8'(livesOut), 8'd0);
        checkOutput("dec4_state", 8'(stateOut), 8'd1);
        tick(1);

        pulse(1'b1, 1'b1, 1'b0);
        checkOutput("restart_lives", 8'(livesOut), 8'd3);
        checkOutput("restart_level", 8'(levelOut), 8'd0);
        checkOutput("restart_state", 8'(stateOut), 8'd0);
        checkOutput("restart_load", 8'(levelLoad), 8'd1);
        tick(1);
        checkOutput("restart_load_off", 8'(levelLoad), 8'd0);
        checkOutput("restart_cmpLives", 8'(compLives), 8'd1);

        pulse(1'b1, 1'b0, 1'b1);
        checkOutput("inc1_level", 8'(levelOut), 8'd1);
        checkOutput("inc1_load", 8'(levelLoad), 8'd1);
        tick(1);
        checkOutput("inc1_load_off", 8'(levelLoad), 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick(1);
        checkOutput("held_level", 8'(levelOut), 8'd2);
        checkOutput("held_load", 8'(levelLoad), 8'd1);
        tick(9);
        checkOutput("held_level_after", 8'(levelOut), 8'd2);
        checkOutput("held_load_after", 8'(levelLoad), 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        checkOutput("inc3_level", 8'(levelOut), 8'd3);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        checkOutput("inc4_level", 8'(levelOut), 8'd4);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        checkOutput("inc5_level", 8'(levelOut), 8'd5);
        checkOutput("inc5_state", 8'(stateOut), 8'd2);
        checkOutput("inc5_load", 8'(levelLoad), 8'd1);
        checkOutput("inc5_cmpLevels_lag", 8'(compLevels), 8'd0);
        tick(1);
        checkOutput("inc5_cmpLevels", 8'(compLevels), 8'd1);
        checkOutput("inc5_load_off", 8'(levelLoad), 8'd0);
        pulse(1'b1, 1'b0, 1'b1);
        checkOutput("inc6_level", 8'(levelOut), 8'd5);
        checkOutput("inc6_load", 8'(levelLoad), 8'd0);
        checkOutput("win_lives", 8'(livesOut), 8'd3);
        tick(1);

        pulse(1'b1, 1'b1, 1'b0);
        checkOutput("winRestart_state", 8'(stateOut), 8'd0);
        checkOutput("winRestart_level", 8'(levelOut), 8'd0);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        tick(1);
        pulse(1'b0, 1'b1, 1'b1);
        tick(1);
        pulse(1'b0, 1'b1, 1'b1);
        tick(1);
        checkOutput("pre_both1_lives", 8'(livesOut), 8'd1);
        checkOutput("pre_both1_level", 8'(levelOut), 8'd2);
        pulse(1'b0, 1'b0, 1'b1);
        checkOutput("both1_lives", 8'(livesOut), 8'd0);
        checkOutput("both1_level", 8'(levelOut), 8'd2);
        checkOutput("both1_state", 8'(stateOut), 8'd1);
        checkOutput("both1_load", 8'(levelLoad), 8'd0);
        tick(1);

        pulse(1'b1, 1'b1, 1'b0);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        tick(1);
        pulse(1'b0, 1'b1, 1'b1);
        tick(1);
        pulse(1'b0, 1'b0, 1'b1);
        checkOutput("both2_lives", 8'(livesOut), 8'd1);
        checkOutput("both2_level", 8'(levelOut), 8'd3);
        checkOutput("both2_state", 8'(stateOut), 8'd0);
        checkOutput("both2_load", 8'(levelLoad), 8'd1);
        tick(1);

        pulse(1'b1, 1'b1, 1'b0);
        checkOutput("playStart_lives", 8'(livesOut), 8'd1);
        checkOutput("playStart_level", 8'(levelOut), 8'd3);
        checkOutput("playStart_load", 8'(levelLoad), 8'd0);
        tick(1);

        applyStimulus(1'b0, 1'b1, 1'b1);
        resetInHigh = 1'b1;
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        resetInHigh = 1'b0;
        tick(2);
        checkOutput("midRst_lives", 8'(livesOut), 8'd3);
        checkOutput("midRst_level", 8'(levelOut), 8'd0);
        checkOutput("midRst_state", 8'(stateOut), 8'd0);
        checkOutput("midRst_load", 8'(levelLoad), 8'd0);

        pulse(1'b0, 1'b1, 1'b1);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        checkOutput("lvl2_level", 8'(levelOut), 8'd2);
`ifdef SC_GAMESTATUS_BONUS_LIFE_EN
        checkOutput("bonus_lives", 8'(livesOut), 8'd3);
`else
        checkOutput("noBonus_lives", 8'(livesOut), 8'd2);
`endif
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        tick(1);
        pulse(1'b1, 1'b0, 1'b1);
        checkOutput("lvl4_level", 8'(levelOut), 8'd4);
`ifdef SC_GAMESTATUS_BONUS_LIFE_EN
        checkOutput("bonusSat_lives", 8'(livesOut), 8'd3);
`else
        checkOutput("noBonus4_lives", 8'(livesOut), 8'd2);
`endif
        tick(1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
